// File: rtl/bist_controller.sv
`default_nettype none
// ============================================================================
// Module      : bist_controller
// Description : LFSR/MISR BIST sequencer for a combinational CUT with a
//               transparent system-mode input mux. The optional macro
//               BIST_CTL_SIG_OUT_EN exposes the MISR as output `signature`.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_controller #(
    parameter int              N_PI          = 35,
    parameter int              N_PO          = 49,
    parameter int              PATTERN_COUNT = 2000,
    parameter logic [N_PI-1:0] LFSR_SEED     = {{(N_PI-1){1'b0}}, 1'b1},
    parameter logic [N_PO-1:0] GOLDEN_SIG    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bistmode,
    input  logic [N_PI-1:0] sys_pi,
    output logic [N_PI-1:0] cut_pi,
    input  logic [N_PO-1:0] cut_po,
    output logic            bistdone,
    output logic            bistpass
`ifdef BIST_CTL_SIG_OUT_EN
    ,
    output logic [N_PO-1:0] signature
`endif
);

    // Feedback taps: x^35+x^33+1 and x^49+x^40+1.
    localparam int          c_LFSR_TAP = N_PI - 3;
    localparam int          c_MISR_TAP = N_PO - 10;
    localparam logic [15:0] c_LAST_CNT = 16'(PATTERN_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [N_PI-1:0] r_lfsr,  w_lfsr_nxt;
    logic [N_PO-1:0] r_misr,  w_misr_nxt;
    logic [15:0]     r_cnt,   w_cnt_nxt;
    logic            r_done,  w_done_nxt;
    logic            r_pass,  w_pass_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_lfsr  <= LFSR_SEED;
            r_misr  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_misr  <= w_misr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_misr_nxt  = r_misr;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        cut_pi      = r_lfsr;

        case (r_state)
            S_IDLE: begin
                cut_pi = sys_pi;
                if (bistmode) begin
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                // LFSR still holds the previous run's tail here, so keep the pins.
                cut_pi = sys_pi;
                if (!bistmode) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_lfsr_nxt  = LFSR_SEED;
                    w_misr_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!bistmode) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_misr_nxt = {r_misr[N_PO-2:0], r_misr[N_PO-1] ^ r_misr[c_MISR_TAP]} ^ cut_po;
                    w_lfsr_nxt = {r_lfsr[N_PI-2:0], r_lfsr[N_PI-1] ^ r_lfsr[c_LFSR_TAP]};
                    w_cnt_nxt  = r_cnt + 16'd1;
                    if (r_cnt == c_LAST_CNT) begin
                        w_state_nxt = S_COMPARE;
                    end
                end
            end
            S_COMPARE: begin
                if (!bistmode) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_pass_nxt  = (r_misr == GOLDEN_SIG);
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!bistmode) begin
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bistdone = r_done;
    assign bistpass = r_pass;

`ifdef BIST_CTL_SIG_OUT_EN
    assign signature = r_misr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bist_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_bist_controller
// Description : Randomized self-checking bench for bist_controller with a
//               pattern-indexed CUT model and a reference signature model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bist_controller;

    localparam int          PC   = 4;
    localparam logic [34:0] SEED = 35'h1;
    localparam logic [48:0] GOLD = 49'h0;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        bistmode = 1'b0;
    logic [34:0] sys_pi   = '0;
    logic [34:0] cut_pi;
    logic [48:0] cut_po;
    logic        bistdone;
    logic        bistpass;
`ifdef BIST_CTL_SIG_OUT_EN
    logic [48:0] signature;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit watch    = 1'b0;

    logic [34:0] pat  [0:PC];
    logic [48:0] resp [0:PC-1];

    always #5 clk = ~clk;

    bist_controller #(
        .N_PI          (35),
        .N_PO          (49),
        .PATTERN_COUNT (PC),
        .LFSR_SEED     (SEED),
        .GOLDEN_SIG    (GOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bistmode  (bistmode),
        .sys_pi    (sys_pi),
        .cut_pi    (cut_pi),
        .cut_po    (cut_po),
        .bistdone  (bistdone),
        .bistpass  (bistpass)
`ifdef BIST_CTL_SIG_OUT_EN
        ,
        .signature (signature)
`endif
    );

    // CUT stand-in: each applied pattern gets its own chosen response.
    always_comb begin
        cut_po = '0;
        for (int k = 0; k < PC; k++) begin
            if (cut_pi == pat[k]) cut_po = resp[k];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [34:0] next_pattern(input logic [34:0] v);
        return {v[33:0], v[34] ^ v[32]};
    endfunction

    function automatic logic [48:0] fold(input logic [48:0] m, input logic [48:0] r);
        return {m[47:0], m[48] ^ m[39]} ^ r;
    endfunction

    always @(negedge clk) begin
        if (watch) check("pass_without_done", 64'(bistpass & ~bistdone), 64'(0));
    end

    // mode 0: zeros, 1: constant 1, 2: random, 3: random with a zero-signature tail
    task automatic pick_resp(input int mode, output logic [48:0] sig);
        logic [48:0] m;
        m = '0;
        for (int k = 0; k < PC; k++) begin
            case (mode)
                0:       resp[k] = '0;
                1:       resp[k] = 49'h1;
                default: resp[k] = 49'({$urandom(), $urandom()});
            endcase
            if (mode == 3 && k == PC - 1) resp[k] = fold(m, 49'h0);
            m = fold(m, resp[k]);
        end
        sig = m;
    endtask

    // Called at a negedge; the next posedge is E0.
    task automatic run_bist(input bit raise, input logic [48:0] exp_sig, input int hold);
        logic exp_pass;
        exp_pass = (exp_sig == GOLD);
        if (raise) bistmode = 1'b1;
        @(posedge clk); @(negedge clk);
        check("init_done", 64'(bistdone), 64'(0));
        for (int k = 0; k < PC; k++) begin
            @(posedge clk); @(negedge clk);
            check("run_pattern", 64'(cut_pi), 64'(pat[k]));
            check("run_done", 64'(bistdone), 64'(0));
        end
        @(posedge clk); @(negedge clk);
        check("compare_pattern", 64'(cut_pi), 64'(pat[PC]));
        check("compare_done", 64'(bistdone), 64'(0));
        @(posedge clk); @(negedge clk);
        check("done_rise", 64'(bistdone), 64'(1));
        check("done_pass", 64'(bistpass), 64'(exp_pass));
`ifdef BIST_CTL_SIG_OUT_EN
        check("signature", 64'(signature), 64'(exp_sig));
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            check("done_hold", 64'(bistdone), 64'(1));
            check("pass_hold", 64'(bistpass), 64'(exp_pass));
            check("pattern_hold", 64'(cut_pi), 64'(pat[PC]));
        end
        bistmode = 1'b0;
        @(posedge clk); @(negedge clk);
        check("exit_done", 64'(bistdone), 64'(0));
        check("exit_pass", 64'(bistpass), 64'(0));
        check("exit_sysmode", 64'(cut_pi), 64'(sys_pi));
    endtask

    initial begin
        logic [48:0] sig;
        pat[0] = SEED;
        for (int k = 0; k < PC; k++) pat[k+1] = next_pattern(pat[k]);

        sys_pi = 35'h5_5555_5555;
        repeat (3) @(negedge clk);
        check("reset_cut_pi", 64'(cut_pi), 64'(sys_pi));
        check("reset_done", 64'(bistdone), 64'(0));
`ifdef BIST_CTL_SIG_OUT_EN
        check("reset_signature", 64'(signature), 64'(0));
`endif
        rst   = 1'b1;
        watch = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("sys_cut_pi", 64'(cut_pi), 64'(35'h5_5555_5555));
            check("sys_done", 64'(bistdone), 64'(0));
            check("sys_pass", 64'(bistpass), 64'(0));
        end

        pick_resp(0, sig);
        run_bist(1'b1, sig, 2);
        pick_resp(1, sig);
        run_bist(1'b1, sig, 1);

        for (int it = 0; it < 10; it++) begin
            sys_pi = 35'({$urandom(), $urandom()});
            pick_resp(int'($urandom_range(0, 3)), sig);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_bist(1'b1, sig, int'($urandom_range(0, 3)));
        end

        // Abort at RUN cycle 2, then restart from the seed.
        sys_pi   = 35'({$urandom(), $urandom()});
        bistmode = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_run_pattern", 64'(cut_pi), 64'(pat[1]));
        bistmode = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort_idle", 64'(cut_pi), 64'(sys_pi));
        check("abort_done", 64'(bistdone), 64'(0));
        @(posedge clk); @(negedge clk);
        check("abort_done_stays", 64'(bistdone), 64'(0));
        pick_resp(3, sig);
        run_bist(1'b1, sig, 1);

        // Asynchronous reset pulse at RUN cycle 1.
        sys_pi = 35'({$urandom(), $urandom()});
        pick_resp(2, sig);
        bistmode = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("prereset_pattern", 64'(cut_pi), 64'(pat[0]));
        #1 rst = 1'b0;
        #1;
        check("async_cut_pi", 64'(cut_pi), 64'(sys_pi));
        check("async_done", 64'(bistdone), 64'(0));
        #2 rst = 1'b1;
        run_bist(1'b0, sig, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
